f2i_pipe: RTL and testbench

- Pipelined IEEE-754 single-precision float to 32-bit signed integer converter. It is the reverse of the integer-to-float block, and the FPU datapath uses it for cvt.w.s-style conversions.
- Result is truncated toward zero and reports precision loss and invalid conversions.
- Sits between the FPU operand register and the integer writeback, with a valid/ready handshake on both sides.

---
 rtl/f2i_pipe_if.sv | 23 ++
 rtl/f2i_pipe.sv | 176 +++++++++++++++++
 tb/tb_f2i_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/f2i_pipe_if.sv
// Handshake and data bundle for the float-to-integer converter.
// The slave side is the converter; the master side is whoever feeds
// operands in and collects integer results.
interface f2i_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        p_lost;
    logic        invalid;

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, d, p_lost, invalid
    );

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, d, p_lost, invalid
    );
endinterface

// File: rtl/f2i_pipe.sv
// Three-stage IEEE-754 single-precision to int32 converter, truncating
// toward zero. S1 decodes the operand, S2 aligns the significand to an
// integer magnitude, S3 applies the sign and selects the invalid result.
// All stages advance together under one global enable, so a stalled
// output freezes the whole pipe and bubbles travel as valid=0 slots.
module f2i_pipe (
    input  logic     clk,
    input  logic     rst,
    f2i_pipe_if.slave bus
);

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] NEG_2P31 = 32'hCF00_0000;

    logic en;

    // S1 (decode) state
    logic              v1_q,       v1_d;
    logic              sign1_q,    sign1_d;
    logic signed [8:0] e1_q,       e1_d;
    logic [23:0]       m1_q,       m1_d;
    logic              nan_inf1_q, nan_inf1_d;
    logic              tiny1_q,    tiny1_d;
    logic              neg_min1_q, neg_min1_d;
    logic              nz1_q,      nz1_d;

    // S2 (align) state
    logic              v2_q,       v2_d;
    logic              sign2_q,    sign2_d;
    logic [31:0]       mag2_q,     mag2_d;
    logic              lost2_q,    lost2_d;
    logic              bad2_q,     bad2_d;
    logic              min2_q,     min2_d;

    // S3 (output) state
    logic              out_valid_q, out_valid_d;
    logic [31:0]       d_q,         d_d;
    logic              p_lost_q,    p_lost_d;
    logic              invalid_q,   invalid_d;

    // One enable for every stage: the pipe moves only if the output slot
    // is empty or being taken this cycle.
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.p_lost    = p_lost_q;
    assign bus.invalid   = invalid_q;

    // S1 next state: split the operand into sign, unbiased exponent,
    // significand with hidden bit, and the class flags S2 needs.
    always_comb begin
        v1_d       = bus.in_valid;
        sign1_d    = bus.a[31];
        e1_d       = $signed({1'b0, bus.a[30:23]}) - 9'sd127;
        m1_d       = {1'b1, bus.a[22:0]};
        nan_inf1_d = (bus.a[30:23] == 8'hFF);
        tiny1_d    = (bus.a[30:23] < 8'd127);
        neg_min1_d = (bus.a == NEG_2P31);
        nz1_d      = |bus.a[30:0];
    end

    // S1 register: capture the decoded operand when the pipe advances.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the datapath registers are reset along with the valid bits
        // so d/p_lost/invalid read 0 after reset; only the valid bits are
        // needed for correct handshaking.
        if (rst) begin
            v1_q       <= 1'b0;
            sign1_q    <= 1'b0;
            e1_q       <= '0;
            m1_q       <= '0;
            nan_inf1_q <= 1'b0;
            tiny1_q    <= 1'b0;
            neg_min1_q <= 1'b0;
            nz1_q      <= 1'b0;
        end else if (en) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the previous stage's value from before the edge.
            v1_q       <= v1_d;
            sign1_q    <= sign1_d;
            e1_q       <= e1_d;
            m1_q       <= m1_d;
            nan_inf1_q <= nan_inf1_d;
            tiny1_q    <= tiny1_d;
            neg_min1_q <= neg_min1_d;
            nz1_q      <= nz1_d;
        end
    end

    // S2 next state: range classification and shift of the significand
    // into an integer magnitude, collecting any discarded fraction bits.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the if/else chain leaves one unassigned (no latches).
        v2_d    = v1_q;
        sign2_d = sign1_q;
        mag2_d  = '0;
        lost2_d = 1'b0;
        bad2_d  = 1'b0;
        min2_d  = 1'b0;
        if (nan_inf1_q) begin
            bad2_d = 1'b1;
        end else if (e1_q >= 9'sd31) begin
            // Only -2^31 itself is representable at this magnitude.
            if (neg_min1_q) begin
                min2_d = 1'b1;
            end else begin
                bad2_d = 1'b1;
            end
        end else if (tiny1_q) begin
            // |a| < 1: magnitude is zero, anything nonzero was lost (±0 is not).
            lost2_d = nz1_q;
        end else if (e1_q >= 9'sd23) begin
            // Integer with no fraction bits: shift left by 0..7.
            mag2_d = {8'h00, m1_q} << (e1_q - 9'sd23);
        end else begin
            // 0 <= e < 23: shift right by 1..23, OR the bits that fall off.
            mag2_d  = {8'h00, m1_q >> (9'sd23 - e1_q)};
            lost2_d = |(m1_q & ~(24'hFF_FFFF << (9'sd23 - e1_q)));
        end
    end

    // S2 register: capture aligned magnitude and range flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            mag2_q  <= '0;
            lost2_q <= 1'b0;
            bad2_q  <= 1'b0;
            min2_q  <= 1'b0;
        end else if (en) begin
            v2_q    <= v2_d;
            sign2_q <= sign2_d;
            mag2_q  <= mag2_d;
            lost2_q <= lost2_d;
            bad2_q  <= bad2_d;
            min2_q  <= min2_d;
        end
    end

    // S3 next state: apply the sign, or substitute INT_MIN for invalid
    // operands and for the exact -2^31 case.
    always_comb begin
        out_valid_d = v2_q;
        d_d         = sign2_q ? (32'd0 - mag2_q) : mag2_q;
        p_lost_d    = lost2_q;
        invalid_d   = 1'b0;
        if (bad2_q) begin
            d_d       = INT_MIN;
            p_lost_d  = 1'b0;
            invalid_d = 1'b1;
        end else if (min2_q) begin
            d_d       = INT_MIN;
            p_lost_d  = 1'b0;
        end
    end

    // S3 register: output slot, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            p_lost_q    <= 1'b0;
            invalid_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            p_lost_q    <= p_lost_d;
            invalid_q   <= invalid_d;
        end
    end

endmodule

// File: tb/tb_f2i_pipe.sv
// Self-checking bench for f2i_pipe: directed values, backpressure,
// mid-stream reset and a randomized run against an arithmetic model.
module tb_f2i_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        p_lost;
        logic        invalid;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    f2i_pipe_if bus();

    f2i_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    res_t sb[$];

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: value = significand * 2^(exp-150) as an exact integer,
    // truncated, then range-checked against the int32 range.
    function automatic res_t model(input logic [31:0] x);
        res_t   r;
        int     ex;
        int     sh;
        longint sig;
        longint mag;
        longint v;
        logic   lost;
        r.d = 32'd0; r.p_lost = 1'b0; r.invalid = 1'b0;
        ex  = int'(x[30:23]);
        if (ex == 255) begin
            r.d = 32'h8000_0000; r.invalid = 1'b1;
            return r;
        end
        sig = (ex == 0) ? longint'(x[22:0]) : longint'({1'b1, x[22:0]});
        sh  = (ex == 0) ? -149 : ex - 150;
        if (sh > 30) begin
            r.d = 32'h8000_0000; r.invalid = 1'b1;
            return r;
        end
        if (sh >= 0) begin
            mag  = sig <<< sh;
            lost = 1'b0;
        end else if (-sh >= 62) begin
            mag  = 0;
            lost = (sig != 0);
        end else begin
            mag  = sig >>> (-sh);
            lost = ((mag <<< (-sh)) != sig);
        end
        v = x[31] ? -mag : mag;
        if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
            r.d = 32'h8000_0000; r.invalid = 1'b1;
            return r;
        end
        r.d      = v[31:0];
        r.p_lost = lost;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        int unsigned pick;
        x    = $urandom();
        pick = $urandom_range(0, 9);
        if (pick < 5) begin
            x[30:23] = 8'($urandom_range(100, 165));
        end else if (pick == 5) begin
            x[30:23] = 8'hFF;
        end else if (pick == 6) begin
            x[30:23] = 8'h00;
        end else if (pick == 7) begin
            x = ($urandom_range(0, 1) != 0) ? 32'hCF00_0000 : 32'h4F00_0000;
        end
        return x;
    endfunction

    // Monitor: every output transfer pops one expected result.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none at %0t", bus.d, $time);
            end else begin
                check("result", {bus.d, bus.p_lost, bus.invalid}, sb.pop_front());
            end
        end
    end

    // Offer one operand and wait (bounded) for it to be accepted.
    task automatic send(input logic [31:0] val);
        logic acc;
        acc          = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = val;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) sb.push_back(model(val));
            @(posedge clk);
            #1;
            if (acc) break;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("send_accept", 34'(acc), 34'd1);
    endtask

    // Cycles from the accepting edge until out_valid is seen (1 = next cycle).
    task automatic wait_latency(output int lat);
        lat = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            lat++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 34'(sb.size()), 34'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] dir_ops[11];
        logic [31:0] ops[5];
        logic [31:0] held_d;
        logic [7:0]  seen;
        int          lat;
        int          sent;
        int          stale;

        bus.in_valid  = 1'b0;
        bus.a         = 32'd0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("reset_out_valid", 34'(bus.out_valid), 34'd0);
        check("reset_d", 34'(bus.d), 34'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 34'(bus.in_ready), 34'd1);
        @(posedge clk);
        #1;

        // Basic values with latency
        send(32'h42F6_0000);
        wait_latency(lat);
        check("latency_pos", 34'(lat), 34'd3);
        send(32'hC2F6_0000);
        wait_latency(lat);
        check("latency_neg", 34'(lat), 34'd3);

        // Truncation and range edges, back to back
        dir_ops = '{32'h42F6_0000, 32'h3FC0_0000, 32'hBF00_0000, 32'h8000_0000,
                    32'h0000_0001, 32'h4EFF_FFFF, 32'h4F00_0000, 32'hCF00_0000,
                    32'h7FC0_0000, 32'hFF80_0000, 32'hC2F6_0000};
        foreach (dir_ops[i]) send(dir_ops[i]);
        drain();

        // Backpressure: five operands into a stalled output
        foreach (ops[i]) ops[i] = rand_op();
        sent          = 0;
        held_d        = 32'd0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = ops[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.a));
                sent++;
            end
            if (c == 3) held_d = bus.d;
            @(posedge clk);
            #1;
            bus.in_valid = (sent < 5) && ((c < 3) || c[0]);
            bus.a        = ops[(sent < 5) ? sent : 4];
        end
        @(negedge clk);
        check("stall_accepts", 34'(sent), 34'd3);
        check("stall_in_ready", 34'(bus.in_ready), 34'd0);
        check("stall_out_valid", 34'(bus.out_valid), 34'd1);
        check("stall_d_held", 34'(bus.d), 34'(held_d));
        check("stall_first_result", {bus.d, bus.p_lost, bus.invalid}, sb[0]);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.a         = ops[sent];
        bus.out_ready = 1'b1;
        seen          = 8'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.a));
                sent++;
            end
            seen[c] = bus.out_valid;
            @(posedge clk);
            #1;
            bus.in_valid = (sent < 5);
            bus.a        = ops[(sent < 5) ? sent : 4];
        end
        check("release_pattern", 34'(seen), 34'h1F);
        drain();

        // Reset with two operands in flight
        send(32'h4040_0000);
        send(32'h40A0_0000);
        @(posedge clk);
        #1;
        check("pre_reset_out_valid", 34'(bus.out_valid), 34'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_out_valid", 34'(bus.out_valid), 34'd0);
        check("async_reset_d", 34'(bus.d), 34'd0);
        sb.delete();
        #12;
        rst   = 1'b0;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("no_stale_outputs", 34'(stale), 34'd0);
        @(posedge clk);
        #1;
        send(32'h3F80_0000);
        wait_latency(lat);
        check("post_reset_latency", 34'(lat), 34'd3);
        drain();

        // Random regression
        sent          = 0;
        bus.in_valid  = ($urandom_range(0, 9) < 7);
        bus.a         = rand_op();
        bus.out_ready = ($urandom_range(0, 9) < 7);
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.a));
                sent++;
            end
            @(posedge clk);
            #1;
            bus.in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
            bus.a         = rand_op();
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        bus.in_valid = 1'b0;
        check("random_sent", 34'(sent), 34'd10000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
